// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM pair with dead-time insertion, driven by an external modulo count.
// Duty words are double-buffered and only take effect at the period boundary.
module pwm_deadtime_gen #(
  parameter  int MOD  = 100000,
  parameter  int DEAD = 4,
  localparam int CW   = $clog2(MOD),
  localparam int DW   = $clog2(MOD + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [CW-1:0] i_count,
  input  logic [DW-1:0] i_duty,
  input  logic          i_duty_valid,
  output logic          o_duty_ready,
  output logic          o_pwm_h,
  output logic          o_pwm_l,
  output logic          o_period_start
);

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_DT_LH = 2'd1,
    ST_HIGH  = 2'd2,
    ST_DT_HL = 2'd3
  } state_t;

  localparam int             DTW       = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
  localparam logic [DTW-1:0] DT_LOAD   = (DEAD > 0) ? DTW'(DEAD - 1) : {DTW{1'b0}};
  localparam logic [DTW-1:0] DT_ZERO   = {DTW{1'b0}};
  localparam logic [DW-1:0]  MOD_D     = DW'(MOD);
  localparam logic [CW-1:0]  LAST_CNT  = CW'(MOD - 1);
  localparam logic [CW-1:0]  ZERO_CNT  = {CW{1'b0}};
  localparam state_t         RST_STATE = (DEAD == 0) ? ST_LOW : ST_DT_HL;

  logic [DW-1:0]  pend_duty_r;
  logic           pend_full_r;
  logic [DW-1:0]  act_duty_r;
  logic           raw_q_r;
  logic           period_start_r;
  state_t         state_r;
  logic [DTW-1:0] dt_cnt_r;
  logic           pwm_h_r;
  logic           pwm_l_r;
  logic           xfer_s;
  logic           wrap_s;

  function automatic logic [DW-1:0] clamp_duty(input logic [DW-1:0] d);
    if (d > MOD_D) begin
      return MOD_D;
    end else begin
      return d;
    end
  endfunction

  assign xfer_s         = i_duty_valid && !pend_full_r;
  assign wrap_s         = (i_count == LAST_CNT);
  assign o_duty_ready   = !pend_full_r;
  assign o_pwm_h        = pwm_h_r;
  assign o_pwm_l        = pwm_l_r;
  assign o_period_start = period_start_r;

  // Pending/active duty registers; a word accepted on the wrap edge waits one more period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_duty_r <= {DW{1'b0}};
      pend_full_r <= 1'b0;
      act_duty_r  <= {DW{1'b0}};
    end else if (wrap_s && pend_full_r) begin
      act_duty_r  <= pend_duty_r;
      pend_full_r <= 1'b0;
    end else if (xfer_s) begin
      pend_duty_r <= clamp_duty(i_duty);
      pend_full_r <= 1'b1;
    end
  end

  // Registered compare of the upstream count against the active duty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      raw_q_r        <= 1'b0;
      period_start_r <= 1'b0;
    end else begin
      raw_q_r        <= (DW'(i_count) < act_duty_r);
      period_start_r <= (i_count == ZERO_CNT);
    end
  end

  // Dead-time FSM; outputs are registered from the state being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= RST_STATE;
      dt_cnt_r <= DT_LOAD;
      pwm_h_r  <= 1'b0;
      pwm_l_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_LOW: begin
          if (raw_q_r && (DEAD == 0)) begin
            state_r <= ST_HIGH;
            pwm_h_r <= 1'b1;
            pwm_l_r <= 1'b0;
          end else if (raw_q_r) begin
            state_r  <= ST_DT_LH;
            dt_cnt_r <= DT_LOAD;
            pwm_h_r  <= 1'b0;
            pwm_l_r  <= 1'b0;
          end else begin
            pwm_h_r <= 1'b0;
            pwm_l_r <= 1'b1;
          end
        end
        ST_DT_LH: begin
          if (!raw_q_r) begin
            state_r <= ST_LOW;
            pwm_h_r <= 1'b0;
            pwm_l_r <= 1'b1;
          end else if (dt_cnt_r == DT_ZERO) begin
            state_r <= ST_HIGH;
            pwm_h_r <= 1'b1;
            pwm_l_r <= 1'b0;
          end else begin
            dt_cnt_r <= dt_cnt_r - DTW'(1);
            pwm_h_r  <= 1'b0;
            pwm_l_r  <= 1'b0;
          end
        end
        ST_HIGH: begin
          if (!raw_q_r && (DEAD == 0)) begin
            state_r <= ST_LOW;
            pwm_h_r <= 1'b0;
            pwm_l_r <= 1'b1;
          end else if (!raw_q_r) begin
            state_r  <= ST_DT_HL;
            dt_cnt_r <= DT_LOAD;
            pwm_h_r  <= 1'b0;
            pwm_l_r  <= 1'b0;
          end else begin
            pwm_h_r <= 1'b1;
            pwm_l_r <= 1'b0;
          end
        end
        ST_DT_HL: begin
          if (raw_q_r) begin
            state_r <= ST_HIGH;
            pwm_h_r <= 1'b1;
            pwm_l_r <= 1'b0;
          end else if (dt_cnt_r == DT_ZERO) begin
            state_r <= ST_LOW;
            pwm_h_r <= 1'b0;
            pwm_l_r <= 1'b1;
          end else begin
            dt_cnt_r <= dt_cnt_r - DTW'(1);
            pwm_h_r  <= 1'b0;
            pwm_l_r  <= 1'b0;
          end
        end
        default: begin
          state_r  <= RST_STATE;
          dt_cnt_r <= DT_LOAD;
          pwm_h_r  <= 1'b0;
          pwm_l_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
